// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline payload types and reset constants for the ysyx core.
// Stage registers build RST_VAL from these named fields.
package ysyx_22040125_pipe_pkg;

    localparam logic [63:0] PC_RST   = 64'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu_res;
        logic [63:0] st_data;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] wb_data;
        logic [4:0]  rd;
        logic        wen;
    } mem_wb_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

    localparam if_id_t IF_ID_RST = '{
        pc:   PC_RST,
        inst: NOP_INST
    };

    localparam id_ex_t ID_EX_RST = '{
        pc:      PC_RST,
        inst:    NOP_INST,
        rs1_val: 64'h0,
        rs2_val: 64'h0,
        imm:     64'h0,
        rd:      5'h0,
        ctrl:    16'h0
    };

    localparam ex_mem_t EX_MEM_RST = '{
        pc:      PC_RST,
        alu_res: 64'h0,
        st_data: 64'h0,
        rd:      5'h0,
        ctrl:    16'h0
    };

    localparam mem_wb_t MEM_WB_RST = '{
        pc:      PC_RST,
        wb_data: 64'h0,
        rd:      5'h0,
        wen:     1'b0
    };

    // A held beat that downstream refuses, outside a flush, is a stall.
    function automatic logic stall_event(
        input logic vld,
        input logic rdy,
        input logic fl
    );
        return vld && !rdy && !fl;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// Two-entry skid buffer for pipe_stage_reg; built only when
// PIPE_STAGE_SKID_EN is defined. in_ready comes straight from a flop.
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_buf #(
    parameter int unsigned       DATA_W  = 64,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    logic              main_vld_q;
    logic              main_vld_d;
    logic              skid_vld_q;
    logic              skid_vld_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              in_xfer;
    logic              out_xfer;

    assign in_ready_o  = !skid_vld_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q;
    assign in_xfer     = in_valid_i && !skid_vld_q;
    assign out_xfer    = main_vld_q && out_ready_i;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_d     = RST_VAL;
            skid_d     = RST_VAL;
        end else if (out_xfer || !main_vld_q) begin
            // Main slot frees up: the older skid beat goes first.
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (in_xfer) begin
                main_vld_d = 1'b1;
                main_d     = in_data_i;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_vld_d = 1'b1;
            skid_d     = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= RST_VAL;
            skid_q     <= RST_VAL;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for a registered in_ready via pipe_skid_buf.
module pipe_stage_reg
    import ysyx_22040125_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W  = 64,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_buf #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk         (clk),
        .rst_ni      (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );
`else
    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              in_xfer;

    // Combinational from out_ready: a draining beat frees the slot now.
    assign in_ready  = out_ready || !valid_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = RST_VAL;
        end else if (in_xfer) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
`endif

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign stall_cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (stall_event(out_valid, out_ready, flush)
                     && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the ysyx core. It generalises the fixed-field inter-stage registers into one block with:
- a configurable-width payload and reset payload value
- a valid/ready handshake for stalls
- a synchronous flush that inserts a defined bubble
- a stall-cycle performance counter
One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage packs its fields into one flat payload vector.

Parameters:
DATA_W, 64, payload width in bits (min 1).
RST_VAL, {DATA_W{1'b0}}, payload value on reset and on flush (e.g. NOP encoding, PC 64'h80000000 in its field).
CNT_W, 16, stall counter width (min 1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; one clock; reset is asynchronous and active-low.
flush  in  1  synchronous kill of stage contents; active-high.
in_valid  in  1  upstream beat valid.
in_ready  out  1  stage can accept a beat.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  stage holds a valid beat.
out_ready  in  1  downstream accepts beat.
out_data  out  DATA_W  registered payload.
stall_clr  in  1  synchronous clear of stall_cnt.
stall_cnt  out  CNT_W  saturating count of back-pressure cycles.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - out_valid=0, out_data=RST_VAL, stall_cnt=0.
  - in_ready=1 (non-skid build, since out_valid=0).
  - Skid entry is invalid.
  - Reset mid-transfer discards all held beats.
- Handshake rules:
  - Input transfer when in_valid&&in_ready at a rising edge.
  - Output transfer when out_valid&&out_ready.
  - Latency 1 cycle: a beat accepted at edge N appears on out_data/out_valid after edge N.
- Ready (non-skid build): in_ready = out_ready || !out_valid. This is a combinational path from out_ready.
- Per edge, in priority order:
  1. flush=1: out_valid<=0, out_data<=RST_VAL, skid cleared. Any concurrent input beat is dropped even if in_ready=1.
  2. Input transfer: out_data<=in_data, out_valid<=1.
  3. Output transfer with no input: out_valid<=0, out_data holds its value.
  4. Otherwise hold.
- Simultaneous input and output transfer: the new beat replaces the old one; no bubble, full throughput.
- in_valid with in_ready=0: upstream must hold in_data stable; the stage does not sample it.
- Stall counter:
  - Increments each edge where out_valid&&!out_ready&&!flush.
  - Saturates at all-ones; no wrap.
  - stall_clr has priority over increment; the counter reads 0 after the clear edge.
  - flush does not clear the counter.
- out_data is never X after reset; it always shows RST_VAL or the last accepted payload.

Optional Feature:
Macro PIPE_STAGE_SKID_EN.
- Defined:
  - Instantiates a 2-entry skid buffer; in_ready becomes registered, in_ready = !skid_valid.
  - A beat arriving while out_valid&&!out_ready goes to the skid entry; in_ready drops on the next cycle.
  - On the next output transfer, the skid entry moves to the main register; in_ready returns to 1 one cycle later.
  - Ordering is preserved, and there is no combinational out_ready->in_ready path.
  - flush clears both entries.
- Undefined: single register, combinational in_ready as above. Latency is 1 in both builds.

Decomposition:
- Shared package ysyx_22040125_pipe_pkg holds:
  - PC_RST = 64'h80000000
  - NOP_INST = 32'h00000013
  - per-stage payload width constants
  - packed-struct typedefs for each stage payload, so RST_VAL is built from named fields.
- One natural sub-module: pipe_skid_buf (2-entry buffer, compiled only under PIPE_STAGE_SKID_EN).
- The stall counter stays inline.

Test Plan:
- Reset with RST_VAL=64'h80000000, DATA_W=64, rst=0 for 3 cycles -> out_valid=0, out_data=64'h80000000, stall_cnt=0, in_ready=1; hold rst=0 for 2 clocks mid-stream -> same values.
- Streaming: in_valid=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, out_valid continuously 1, no bubbles.
- Back-pressure: load 0xA5, hold out_ready=0 for 5 cycles with in_valid=1, in_data=0x5A -> out_data stays 0xA5, stall_cnt=5. Non-skid: in_ready=0. Skid: one extra beat accepted, then in_ready=0. Release -> 0xA5 then 0x5A, no loss or duplication.
- Flush with beat pending: out_valid=1, in_valid=1, flush=1 -> next cycle out_valid=0, out_data=RST_VAL, incoming beat absent downstream; stall_cnt unchanged.
- Counter saturation: CNT_W=3, hold stall for 10 cycles -> stall_cnt sticks at 7; stall_clr and stall asserted together -> 0.
- Random in_valid/out_ready at 50% for 10k cycles against a scoreboard -> in-order, lossless delivery in both builds.
